// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Parametrised raster timing generator with a movable image window.
// Produces HS/VS/DE for any porch/sync mode, plus a per-pixel fetch strobe
// and source coordinates for the pixel loader. The window origin is
// shadowed and only takes effect at the frame boundary.
//
// Optional feature macro: VTG_SCALE2X_EN
//   defined   -> 2x pixel replication: the footprint doubles in each axis and
//                one fetch is issued per 2x2 block.
//   undefined -> 1:1 window, no replication logic.
//
// Ports
//   clk        pixel clock, rising edge
//   rst_n      asynchronous active-low reset
//   i_en       run enable; low freezes counters and blanks the outputs
//   i_win_x/y  window origin, sampled at the frame boundary
//   o_hs/o_vs  syncs, active level HS_POL / VS_POL
//   o_de       active video
//   o_x/o_y    raster position of the current output cycle
//   o_win_act  pixel inside the window footprint and the active area
//   o_win_req  fetch strobe: loader advances one source pixel
//   o_src_x/y  source coordinates within the window (0 outside it)
//   o_sof      one-cycle start-of-frame pulse, aligned with pixel (0,0)
//
// All outputs are registered and mutually aligned; they reflect the counter
// state of the previous cycle.
// ---------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int WIN_W    = 225,
  parameter int WIN_H    = 225,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [CW-1:0] i_win_x,
  input  logic [CW-1:0] i_win_y,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_de,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_win_act,
  output logic          o_win_req,
  output logic [CW-1:0] o_src_x,
  output logic [CW-1:0] o_src_y,
  output logic          o_sof
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

`ifdef VTG_SCALE2X_EN
  localparam int FW = 2 * WIN_W;
  localparam int FH = 2 * WIN_H;
`else
  localparam int FW = WIN_W;
  localparam int FH = WIN_H;
`endif

  // Footprint extents at CW+1 bits so origin + size cannot wrap.
  localparam logic [CW:0] FW_EXT = (CW+1)'(FW);
  localparam logic [CW:0] FH_EXT = (CW+1)'(FH);

  // -------------------------------------------------------------------------
  // Raster counters and window-origin shadows
  // -------------------------------------------------------------------------
  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic [CW-1:0] wx_q, wx_d;
  logic [CW-1:0] wy_q, wy_d;

  // NOTE: every signal driven from always_comb gets a default assignment first,
  // so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    wx_d = wx_q;
    wy_d = wy_q;
    if (i_en) begin
      if (hc_q == CW'(H_TOTAL - 1)) begin
        hc_d = '0;
        if (vc_q == CW'(V_TOTAL - 1)) begin
          vc_d = '0;
          // Frame boundary: the new origin applies from pixel (0,0) onward.
          wx_d = i_win_x;
          wy_d = i_win_y;
        end else begin
          vc_d = vc_q + 1'b1;
        end
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Decode of the current counter state
  // -------------------------------------------------------------------------
  logic          de;
  logic          hs_on;
  logic          vs_on;
  logic          win_h;
  logic          win_v;
  logic          act;
  logic          req;
  logic [CW-1:0] rx;
  logic [CW-1:0] ry;
  logic [CW-1:0] src_x;
  logic [CW-1:0] src_y;

  always_comb begin
    de    = (hc_q < CW'(H_ACTIVE)) && (vc_q < CW'(V_ACTIVE));
    hs_on = (hc_q >= CW'(HS_START)) && (hc_q < CW'(HS_END));
    vs_on = (vc_q >= CW'(VS_START)) && (vc_q < CW'(VS_END));
    win_h = ({1'b0, hc_q} >= {1'b0, wx_q}) && ({1'b0, hc_q} < ({1'b0, wx_q} + FW_EXT));
    win_v = ({1'b0, vc_q} >= {1'b0, wy_q}) && ({1'b0, vc_q} < ({1'b0, wy_q} + FH_EXT));
    // Gating by DE clips the window to the active area.
    act   = de && win_h && win_v;
    rx    = hc_q - wx_q;
    ry    = vc_q - wy_q;
`ifdef VTG_SCALE2X_EN
    // One fetch per 2x2 block; odd rows/columns are replicated downstream.
    req   = act && !rx[0] && !ry[0];
    src_x = {1'b0, rx[CW-1:1]};
    src_y = {1'b0, ry[CW-1:1]};
`else
    req   = act;
    src_x = rx;
    src_y = ry;
`endif
  end

  // -------------------------------------------------------------------------
  // Output next-state
  // -------------------------------------------------------------------------
  logic          hs_d, vs_d, de_d, act_d, req_d, sof_d;
  logic [CW-1:0] x_d, y_d, src_x_d, src_y_d;

  always_comb begin
    hs_d    = !HS_POL;
    vs_d    = !VS_POL;
    de_d    = 1'b0;
    act_d   = 1'b0;
    req_d   = 1'b0;
    sof_d   = 1'b0;
    src_x_d = '0;
    src_y_d = '0;
    // Raster position always tracks the counters, so it freezes with them.
    x_d     = hc_q;
    y_d     = vc_q;
    if (i_en) begin
      if (hs_on) hs_d = HS_POL;
      if (vs_on) vs_d = VS_POL;
      de_d  = de;
      act_d = act;
      req_d = req;
      sof_d = (hc_q == '0) && (vc_q == '0);
      if (act) begin
        src_x_d = src_x;
        src_y_d = src_y;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the order of statements cannot create races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Start in blanking so the first frame begins cleanly at (0,0).
      hc_q      <= CW'(H_ACTIVE);
      vc_q      <= CW'(V_ACTIVE);
      wx_q      <= '0;
      wy_q      <= '0;
      o_hs      <= !HS_POL;
      o_vs      <= !VS_POL;
      o_de      <= 1'b0;
      o_win_act <= 1'b0;
      o_win_req <= 1'b0;
      o_sof     <= 1'b0;
      o_x       <= '0;
      o_y       <= '0;
      o_src_x   <= '0;
      o_src_y   <= '0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      o_hs      <= hs_d;
      o_vs      <= vs_d;
      o_de      <= de_d;
      o_win_act <= act_d;
      o_win_req <= req_d;
      o_sof     <= sof_d;
      o_x       <= x_d;
      o_y       <= y_d;
      o_src_x   <= src_x_d;
      o_src_y   <= src_y_d;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Self-checking bench for video_timing_gen using a reduced raster so several
// frames fit in a short run. A behavioural model tracks the raster as a single
// linear pixel position inside the frame and derives every expected output
// from it with plain arithmetic. Honours VTG_SCALE2X_EN when defined.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int HA  = 40;
  localparam int HFP = 4;
  localparam int HSY = 6;
  localparam int HBP = 6;
  localparam int VA  = 30;
  localparam int VFP = 2;
  localparam int VSY = 2;
  localparam int VBP = 3;
  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b0;
  localparam int WIN_W = 15;
  localparam int WIN_H = 12;
  localparam int CW    = 12;

  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int LATENCY = HT * (VT - VA) - HA + 1;

`ifdef VTG_SCALE2X_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int FW = S * WIN_W;
  localparam int FH = S * WIN_H;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [CW-1:0] win_x;
  logic [CW-1:0] win_y;
  logic          o_hs, o_vs, o_de, o_win_act, o_win_req, o_sof;
  logic [CW-1:0] o_x, o_y, o_src_x, o_src_y;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL),
    .WIN_W(WIN_W), .WIN_H(WIN_H), .CW(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (en),
    .i_win_x   (win_x),
    .i_win_y   (win_y),
    .o_hs      (o_hs),
    .o_vs      (o_vs),
    .o_de      (o_de),
    .o_x       (o_x),
    .o_y       (o_y),
    .o_win_act (o_win_act),
    .o_win_req (o_win_req),
    .o_src_x   (o_src_x),
    .o_src_y   (o_src_y),
    .o_sof     (o_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: linear position in the frame plus the origin used
  // by the frame currently being scanned.
  int p_m, wx_m, wy_m;
  int n_vec, n_err;
  int since_sof, last_period, frame_reqs, last_frame_reqs;
  bit sof_flag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requests per frame for a given origin: visible footprint sampled every S.
  function automatic int exp_reqs(input int wx, input int wy);
    int cols, rows;
    cols = (wx >= HA) ? 0 : ((wx + FW > HA) ? HA - wx : FW);
    rows = (wy >= VA) ? 0 : ((wy + FH > VA) ? VA - wy : FH);
    return ((cols + S - 1) / S) * ((rows + S - 1) / S);
  endfunction

  task automatic model_reset();
    p_m  = VA * HT + HA;
    wx_m = 0;
    wy_m = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"},   32'(o_hs),      32'(!HS_POL));
    check({tag, "_vs"},   32'(o_vs),      32'(!VS_POL));
    check({tag, "_de"},   32'(o_de),      0);
    check({tag, "_act"},  32'(o_win_act), 0);
    check({tag, "_req"},  32'(o_win_req), 0);
    check({tag, "_sof"},  32'(o_sof),     0);
    check({tag, "_x"},    32'(o_x),       0);
    check({tag, "_y"},    32'(o_y),       0);
    check({tag, "_srcx"}, 32'(o_src_x),   0);
    check({tag, "_srcy"}, 32'(o_src_y),   0);
  endtask

  // One clock: predict outputs from the model, clock, advance model, compare.
  task automatic step();
    int hc, vc, rx, ry, sx, sy;
    bit de, act, req, hs, vs, sof;
    hc  = p_m % HT;
    vc  = p_m / HT;
    de  = en && (hc < HA) && (vc < VA);
    act = de && (hc >= wx_m) && (hc < wx_m + FW) && (vc >= wy_m) && (vc < wy_m + FH);
    rx  = hc - wx_m;
    ry  = vc - wy_m;
    req = act && (rx % S == 0) && (ry % S == 0);
    sx  = act ? rx / S : 0;
    sy  = act ? ry / S : 0;
    hs  = (en && hc >= HA + HFP && hc < HA + HFP + HSY) ? HS_POL : !HS_POL;
    vs  = (en && vc >= VA + VFP && vc < VA + VFP + VSY) ? VS_POL : !VS_POL;
    sof = en && (p_m == 0);
    @(posedge clk);
    if (en) begin
      if (p_m == FRAME - 1) begin
        p_m  = 0;
        wx_m = int'(win_x);
        wy_m = int'(win_y);
      end else begin
        p_m++;
      end
    end
    @(negedge clk);
    check("hs",   32'(o_hs),      32'(hs));
    check("vs",   32'(o_vs),      32'(vs));
    check("de",   32'(o_de),      32'(de));
    check("x",    32'(o_x),       32'(hc));
    check("y",    32'(o_y),       32'(vc));
    check("act",  32'(o_win_act), 32'(act));
    check("req",  32'(o_win_req), 32'(req));
    check("srcx", 32'(o_src_x),   32'(sx));
    check("srcy", 32'(o_src_y),   32'(sy));
    check("sof",  32'(o_sof),     32'(sof));
    since_sof++;
    if (o_sof) begin
      last_period     = since_sof;
      since_sof       = 0;
      last_frame_reqs = frame_reqs;
      frame_reqs      = 0;
      sof_flag        = 1'b1;
    end
    frame_reqs += int'(o_win_req);
  endtask

  task automatic run_to_sof(input string tag);
    int n;
    sof_flag = 1'b0;
    n = 0;
    while (!sof_flag && n < 2 * FRAME + 10) begin
      step();
      n++;
    end
    check({tag, "_sof_seen"}, 32'(sof_flag), 1);
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int off_left;
    n_vec = 0;
    n_err = 0;
    en    = 1'b1;
    win_x = '0;
    win_y = '0;
    rst_n = 1'b0;
    since_sof = 0;
    frame_reqs = 0;
    last_frame_reqs = 0;
    last_period = 0;
    model_reset();

    // Outputs hold reset values while reset is asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("rst");
    end
    rst_n = 1'b1;

    // First frame start latency, then a full frame with window (0,0).
    run_to_sof("first");
    check("sof_latency", 32'(last_period), 32'(LATENCY));
    run_to_sof("frame0");
    check("sof_period", 32'(last_period), 32'(FRAME));
    check("reqs_origin", 32'(last_frame_reqs), 32'(exp_reqs(0, 0)));

    // Origin change mid-frame: current frame unaffected, next frame moves.
    run_steps(HT * (VA / 2));
    win_x = CW'(7);
    win_y = CW'(5);
    run_to_sof("midchg_a");
    check("reqs_before_move", 32'(last_frame_reqs), 32'(exp_reqs(0, 0)));
    win_x = CW'(HA - 5);
    win_y = CW'(VA - 4);
    run_to_sof("midchg_b");
    check("reqs_moved", 32'(last_frame_reqs), 32'(exp_reqs(7, 5)));
    check("sof_period2", 32'(last_period), 32'(FRAME));

    // Window clipped at the bottom-right corner of the active area.
    run_to_sof("clip");
    check("reqs_clipped", 32'(last_frame_reqs), 32'(exp_reqs(HA - 5, VA - 4)));

    // Random enable gaps and origin changes against the model.
    off_left = 0;
    for (int i = 0; i < 12000; i++) begin
      if (off_left > 0) begin
        off_left--;
        en = (off_left == 0);
      end else if ($urandom_range(0, 199) == 0) begin
        off_left = $urandom_range(1, 60);
        en = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) begin
        win_x = CW'($urandom_range(0, HA + 3));
        win_y = CW'($urandom_range(0, VA + 3));
      end
      step();
    end
    en = 1'b1;

    // Asynchronous reset mid-frame clears everything at once.
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    for (int i = 0; i < 3; i++) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    since_sof = 0;
    frame_reqs = 0;
    run_to_sof("rerun");
    check("sof_latency2", 32'(last_period), 32'(LATENCY));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
